// File: rtl/divmodule.sv
// Iterative signed restoring divider: one quotient bit per cycle, MSB first, with a divide-by-zero flag.
// Optional macro DIVMODULE_EARLY_OUT_EN skips the iterations when |A| < |B|.
module divmodule #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic [WIDTH-1:0] data_remainder,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [CW-1:0]    count;
    logic             sign_q;
    logic             sign_r;
    logic             divzero;

    logic [WIDTH-1:0] abs_a_in;
    logic [WIDTH-1:0] abs_b_in;
    logic             b_zero;
    logic             early_out;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   trial;
    logic             trial_ok;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;

    // Magnitudes wrap naturally: |-2^(W-1)| is the unsigned pattern 2^(W-1).
    always_comb begin
        abs_a_in = data_operandA[WIDTH-1] ? (~data_operandA + 1'b1) : data_operandA;
        abs_b_in = data_operandB[WIDTH-1] ? (~data_operandB + 1'b1) : data_operandB;
        b_zero   = (data_operandB == '0);
    end

`ifdef DIVMODULE_EARLY_OUT_EN
    assign early_out = !b_zero && (abs_a_in < abs_b_in);
`else
    assign early_out = 1'b0;
`endif

    // The shifted remainder stays below 2^W, so bit WIDTH of the trial is a true sign bit.
    always_comb begin
        rem_shift = {rem, quo[WIDTH-1]};
        trial     = rem_shift - {1'b0, abs_b};
        trial_ok  = ~trial[WIDTH];
        rem_next  = trial_ok ? trial[WIDTH-1:0] : rem_shift[WIDTH-1:0];
        quo_next  = {quo[WIDTH-2:0], trial_ok};
    end

    // A start request wins in every state, so a busy divider simply restarts.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            abs_b          <= '0;
            rem            <= '0;
            quo            <= '0;
            count          <= '0;
            sign_q         <= 1'b0;
            sign_r         <= 1'b0;
            divzero        <= 1'b0;
            data_result    <= '0;
            data_remainder <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            data_exception <= 1'b0;
            if (ctrl_DIV) begin
                abs_b   <= abs_b_in;
                sign_q  <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                sign_r  <= data_operandA[WIDTH-1];
                divzero <= b_zero;
                count   <= CW'(WIDTH);
                busy    <= 1'b1;
                if (b_zero) begin
                    quo   <= '0;
                    rem   <= '0;
                    state <= FIX;
                end else if (early_out) begin
                    quo   <= '0;
                    rem   <= abs_a_in;
                    state <= FIX;
                end else begin
                    quo   <= abs_a_in;
                    rem   <= '0;
                    state <= RUN;
                end
            end else begin
                case (state)
                    IDLE: begin
                        busy <= 1'b0;
                    end
                    RUN: begin
                        rem   <= rem_next;
                        quo   <= quo_next;
                        count <= count - CW'(1);
                        if (count == CW'(1)) begin
                            state <= FIX;
                        end
                    end
                    FIX: begin
                        data_result    <= sign_q ? (~quo + 1'b1) : quo;
                        data_remainder <= sign_r ? (~rem + 1'b1) : rem;
                        data_exception <= divzero;
                        data_resultRDY <= 1'b1;
                        busy           <= 1'b0;
                        state          <= IDLE;
                    end
                    default: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_divmodule.sv
// Scoreboard bench for divmodule: stimulus pushes expected results, a negedge monitor pops them on each RDY strobe.
module tb_divmodule;

    localparam int W        = 32;
    localparam int LAT_FULL = W + 1;
`ifdef DIVMODULE_EARLY_OUT_EN
    localparam int LAT_EARLY = 1;
`else
    localparam int LAT_EARLY = LAT_FULL;
`endif

    logic         clock   = 1'b0;
    logic         reset_n = 1'b0;
    logic         ctrl_DIV = 1'b0;
    logic [W-1:0] data_operandA = '0;
    logic [W-1:0] data_operandB = '0;
    logic [W-1:0] data_result;
    logic [W-1:0] data_remainder;
    logic         data_exception;
    logic         data_resultRDY;
    logic         busy;

    int checks   = 0;
    int failures = 0;
    int edge_cnt = 0;

    typedef struct {
        string        name;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         e;
        int           due;
    } exp_t;

    exp_t sb[$];

    divmodule #(.WIDTH(W)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .ctrl_DIV      (ctrl_DIV),
        .data_operandA (data_operandA),
        .data_operandB (data_operandB),
        .data_result   (data_result),
        .data_remainder(data_remainder),
        .data_exception(data_exception),
        .data_resultRDY(data_resultRDY),
        .busy          (busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) edge_cnt <= edge_cnt + 1;

    task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // abort_prev drops the expectation of an operation this start is meant to cancel.
    task automatic applyStimulus(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input logic [W-1:0] eq, input logic [W-1:0] er, input logic ee,
                                 input int lat, input bit abort_prev);
        exp_t x;
        @(negedge clock);
        if (abort_prev && sb.size() > 0) void'(sb.pop_back());
        x.name = name;
        x.q    = eq;
        x.r    = er;
        x.e    = ee;
        x.due  = edge_cnt + 1 + lat;
        sb.push_back(x);
        ctrl_DIV      = 1'b1;
        data_operandA = av;
        data_operandB = bv;
        @(negedge clock);
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    task automatic waitDone(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clock);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL timeout pending=%0d actual=no_rdy required=rdy", sb.size());
            sb.delete();
        end
    endtask

    exp_t got;
    always @(negedge clock) begin
        if (reset_n && data_resultRDY) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_rdy actual=1 required=0 result=0x%08h", data_result);
            end else begin
                got = sb.pop_front();
                checkOutput({got.name, ".result"},    data_result,    got.q);
                checkOutput({got.name, ".remainder"}, data_remainder, got.r);
                checkOutput({got.name, ".exception"}, W'(data_exception), W'(got.e));
                checkOutput({got.name, ".latency"},   W'(edge_cnt),   W'(got.due));
                checkOutput({got.name, ".busy"},      W'(busy),       W'(0));
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clock);
        checkOutput("reset.result",    data_result,          '0);
        checkOutput("reset.remainder", data_remainder,       '0);
        checkOutput("reset.exception", W'(data_exception),   '0);
        checkOutput("reset.rdy",       W'(data_resultRDY),   '0);
        checkOutput("reset.busy",      W'(busy),             '0);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        applyStimulus("basic", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, LAT_FULL, 1'b0);
        checkOutput("basic.busy_start", W'(busy), W'(1));
        repeat (32) @(negedge clock);
        checkOutput("basic.busy_e32", W'(busy),           W'(1));
        checkOutput("basic.rdy_e32",  W'(data_resultRDY), W'(0));
        waitDone(5);

        applyStimulus("neg_a",  32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, LAT_FULL, 1'b0);
        waitDone(40);
        applyStimulus("neg_b",  32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2,        1'b0, LAT_FULL, 1'b0);
        waitDone(40);
        applyStimulus("neg_ab", 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14,       32'hFFFFFFFE, 1'b0, LAT_FULL, 1'b0);
        waitDone(40);

        applyStimulus("divzero", 32'd5, 32'd0, 32'd0, 32'd0, 1'b1, 1, 1'b0);
        @(negedge clock);
        @(negedge clock);
        checkOutput("divzero.exc_clear", W'(data_exception), W'(0));
        checkOutput("divzero.rdy_clear", W'(data_resultRDY), W'(0));
        waitDone(5);

        applyStimulus("overflow", 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0, LAT_FULL, 1'b0);
        waitDone(40);
        repeat (3) @(negedge clock);
        checkOutput("overflow.hold", data_result, 32'h80000000);

        applyStimulus("equal",   32'd7,        32'd7, 32'd1,        32'd0,        1'b0, LAT_FULL, 1'b0);
        waitDone(40);
        applyStimulus("maxpos",  32'h7FFFFFFF, 32'd2, 32'h3FFFFFFF, 32'd1,        1'b0, LAT_FULL, 1'b0);
        waitDone(40);
        applyStimulus("minneg1", 32'h80000000, 32'd1, 32'h80000000, 32'd0,        1'b0, LAT_FULL, 1'b0);
        waitDone(40);

        applyStimulus("early",      32'd3,        32'd10, 32'd0, 32'd3,        1'b0, LAT_EARLY, 1'b0);
        waitDone(40);
        applyStimulus("early_zero", 32'd0,        32'd5,  32'd0, 32'd0,        1'b0, LAT_EARLY, 1'b0);
        waitDone(40);
        applyStimulus("early_neg",  32'hFFFFFFFD, 32'd10, 32'd0, 32'hFFFFFFFD, 1'b0, LAT_EARLY, 1'b0);
        waitDone(40);

        applyStimulus("aborted", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, LAT_FULL, 1'b0);
        repeat (8) @(negedge clock);
        applyStimulus("restart", 32'd50, 32'd5, 32'd10, 32'd0, 1'b0, LAT_FULL, 1'b1);
        waitDone(50);

        applyStimulus("rst_abort", 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, LAT_FULL, 1'b0);
        repeat (4) @(negedge clock);
        @(posedge clock);
        #1 reset_n = 1'b0;
        #1;
        sb.delete();
        checkOutput("rst_async.result", data_result,        '0);
        checkOutput("rst_async.busy",   W'(busy),           '0);
        checkOutput("rst_async.rdy",    W'(data_resultRDY), '0);
        checkOutput("rst_async.rem",    data_remainder,     '0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (40) @(negedge clock);
        checkOutput("rst_abort.busy_idle", W'(busy), W'(0));

        applyStimulus("post_reset", 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, LAT_FULL, 1'b0);
        waitDone(40);

        repeat (3) @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/divmodule.md
Name: divmodule

Overview:
- Iterative signed restoring divider for the processor's multiply/divide unit.
- It is the inverse datapath of the carry-lookahead adder: one trial subtraction per cycle produces one quotient bit, MSB first.
- It takes operands from the execute stage, raises a one-cycle ready strobe, and reports divide-by-zero through an exception flag.
- Pipeline stall logic holds the instruction until the ready strobe.

Parameters:
- WIDTH, 32, operand/result width in bits (must be ≥ 4).

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- ctrl_DIV  in  1  start pulse; operands are sampled on the same edge
- data_operandA  in  WIDTH  dividend (two's complement)
- data_operandB  in  WIDTH  divisor (two's complement)
- data_result  out  WIDTH  quotient (registered)
- data_remainder  out  WIDTH  remainder (registered)
- data_exception  out  1  divide-by-zero flag; valid while data_resultRDY=1
- data_resultRDY  out  1  one-cycle completion strobe
- busy  out  1  high while an operation is in progress

Behaviour:
- Reset (reset_n=0, asynchronous): state IDLE; data_result, data_remainder, data_exception, data_resultRDY, busy all 0; internal registers cleared. Asserting reset mid-operation aborts with no RDY strobe.
- States: IDLE, RUN, FIX.
- IDLE, edge E0 with ctrl_DIV=1:
  - Latch |A| and |B| (WIDTH-bit magnitudes; |−2^(W−1)| is held as unsigned 2^(W−1)).
  - Latch sign_q = A[W−1]^B[W−1] and sign_r = A[W−1].
  - Clear the partial remainder (WIDTH+1 bits) and load iteration counter = WIDTH.
  - busy=1.
  - If B==0: go to FIX with divzero=1 and skip RUN.
  - Otherwise go to RUN.
- RUN, each edge:
  - Shift {rem, quo} left by 1; trial = rem_shifted − |B| (WIDTH+1 bits, adder-style subtract).
  - If trial is non-negative: rem=trial and the new quo LSB=1. Else: restore, LSB=0.
  - Counter decrements. After the WIDTH-th iteration (edge E0+WIDTH), go to FIX.
- FIX, one edge:
  - data_result = sign_q ? −quo : quo.
  - data_remainder = sign_r ? −rem : rem (low WIDTH bits).
  - data_exception = divzero; data_resultRDY=1 for exactly one cycle; busy=0; state goes to IDLE.
- Latency:
  - Normal: RDY high in the cycle following edge E0+WIDTH+1 (33 edges at WIDTH=32).
  - Divide-by-zero: RDY follows edge E0+1, with data_result=0, data_remainder=0, data_exception=1.
- Rounding: quotient truncates toward zero; remainder takes the sign of the dividend; A = Q·B + R always holds for B≠0.
- Overflow (−2^(W−1) / −1): quotient wraps to −2^(W−1), remainder 0, data_exception=0.
- Result registers hold their value after RDY until the next FIX or reset. data_exception clears to 0 on the next cycle.
- ctrl_DIV=1 while busy (RUN or FIX edge): abort the current operation and restart with the new operands from that edge. The aborted operation produces no RDY.
- Operands are don't-care except on the edge where ctrl_DIV=1.

Optional Feature:
- Macro DIVMODULE_EARLY_OUT_EN.
- Defined: at the E0 latch, if B≠0 and |A| < |B| (unsigned), skip RUN. Go directly to FIX with quo=0 and rem=|A|, so RDY follows edge E0+1. All sign rules apply unchanged; the remainder equals A.
- Undefined: every nonzero-divisor operation takes the full WIDTH+1 edges.

Test Plan:
- Basic, WIDTH=32: A=100, B=7, ctrl_DIV pulse at E0 → RDY only after E0+33; result=14, remainder=2, exception=0; busy high from E0 through E0+32.
- Signs: A=−100, B=7 → result=0xFFFFFFF2, remainder=0xFFFFFFFE. A=100, B=−7 → result=0xFFFFFFF2, remainder=2. A=−100, B=−7 → result=14, remainder=0xFFFFFFFE.
- Divide by zero: A=5, B=0 → RDY after E0+1, exception=1, result=0, remainder=0; exception is 0 on the following cycle.
- Overflow: A=0x80000000, B=0xFFFFFFFF → after E0+33, result=0x80000000, remainder=0, exception=0.
- Restart/reset:
  - A=100, B=7 started, then ctrl_DIV with A=50, B=5 at E0+10 → single RDY after E0+43 with result=10, remainder=0.
  - Separately, reset_n=0 at E0+5 → all outputs 0 asynchronously and no RDY afterwards.
- Early out: A=3, B=10 → with DIVMODULE_EARLY_OUT_EN, RDY after E0+1, result=0, remainder=3; without it, the same values after E0+33.
